wb_stage_pipe: RTL and testbench

Parametrised write-back stage that merges the MEM/WB pipeline register with the write-back source mux. It selects one of NSRC result sources (PC+2, memory, ALU, immediate, ...) and registers it. It drives the register-file write port and reports instruction faults with a sticky halt. It sits between the memory stage and the register file, and supports pipeline stall and flush plus a retired-instruction counter.

---
 rtl/wb_stage_pipe.sv | 133 +++++++++++++
 tb/tb_wb_stage_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
// Write-back stage: MEM/WB pipeline register fused with the result-source mux.
// Drives the register-file write port, raises a sticky halt when a faulting
// instruction reaches write-back, and counts retired instructions.
module wb_stage_pipe #(
    parameter int DW   = 16,
    parameter int NSRC = 4,
    parameter int SW   = $clog2(NSRC),
    parameter int RW   = 3,
    parameter int CW   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic [NSRC*DW-1:0] src_data,
    input  logic [SW-1:0]      src_sel,
    input  logic [RW-1:0]      in_rd,
    input  logic               in_we,
    input  logic               in_ferr,
    input  logic               in_merr,
    output logic               wb_valid,
    output logic [DW-1:0]      wb_data,
    output logic [RW-1:0]      wb_rd,
    output logic               wb_we,
    output logic               wb_err,
    output logic               halted,
    output logic [CW-1:0]      retired
);

    // One extra bit so NSRC itself is representable when NSRC is a power of two.
    localparam logic [SW:0]   NSRC_W  = NSRC[SW:0];
    localparam logic [CW-1:0] RET_MAX = {CW{1'b1}};

    logic [DW-1:0] src_arr [NSRC];

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign src_arr[gi] = src_data[gi*DW +: DW];
        end
    endgenerate

    logic          valid_q,   valid_d;
    logic [DW-1:0] data_q,    data_d;
    logic [RW-1:0] rd_q,      rd_d;
    logic          we_q,      we_d;
    logic          err_q,     err_d;
    logic          halted_q,  halted_d;
    logic [CW-1:0] retired_q, retired_d;

    logic          sel_ok;
    logic [DW-1:0] sel_data;
    logic          cap;
    logic          leaving;

    // Source mux; an out-of-range select yields zero and is flagged as a fault.
    always_comb begin
        sel_ok   = ({1'b0, src_sel} < NSRC_W);
        sel_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (src_sel == SW'(k)) begin
                sel_data = src_arr[k];
            end
        end
        if (!sel_ok) begin
            sel_data = '0;
        end
    end

    // Next-state: flush beats stall, stall beats capture, otherwise a bubble.
    always_comb begin
        cap       = in_valid & ~stall & ~flush & ~halted_q;
        leaving   = valid_q & ~err_q & ~stall & ~flush;
        valid_d   = valid_q;
        data_d    = data_q;
        rd_d      = rd_q;
        we_d      = we_q;
        err_d     = err_q;
        halted_d  = halted_q | (valid_q & err_q & ~flush);
        retired_d = retired_q;

        if (flush) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (cap) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            rd_d    = in_rd;
            we_d    = in_we;
            err_d   = in_ferr | in_merr | ~sel_ok;
        end else begin
            valid_d = 1'b0;
            err_d   = 1'b0;
        end

        if (leaving && (retired_q != RET_MAX)) begin
            retired_d = retired_q + 1'b1;
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            err_q     <= err_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign wb_valid = valid_q;
    assign wb_data  = data_q;
    assign wb_rd    = rd_q;
    assign wb_we    = valid_q & we_q & ~err_q;
    assign wb_err   = err_q;
    assign halted   = halted_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe: a default instance (NSRC=4, CW=16)
// and a narrow instance (NSRC=3, CW=4) share the same stimulus.
module tb_wb_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [63:0] src_data = '0;
    logic [1:0]  src_sel = '0;
    logic [2:0]  in_rd = '0;
    logic        in_we = 1'b0, in_ferr = 1'b0, in_merr = 1'b0;

    logic        v0, we0, e0, h0;
    logic [15:0] d0, r0;
    logic [2:0]  rd0;
    logic        v1, we1, e1, h1;
    logic [15:0] d1;
    logic [2:0]  rd1;
    logic [3:0]  r1;

    always #5 clk = ~clk;

    wb_stage_pipe #(.DW(16), .NSRC(4), .RW(3), .CW(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .src_data(src_data), .src_sel(src_sel), .in_rd(in_rd), .in_we(in_we),
        .in_ferr(in_ferr), .in_merr(in_merr),
        .wb_valid(v0), .wb_data(d0), .wb_rd(rd0), .wb_we(we0), .wb_err(e0),
        .halted(h0), .retired(r0));

    wb_stage_pipe #(.DW(16), .NSRC(3), .RW(3), .CW(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .src_data(src_data[47:0]), .src_sel(src_sel), .in_rd(in_rd), .in_we(in_we),
        .in_ferr(in_ferr), .in_merr(in_merr),
        .wb_valid(v1), .wb_data(d1), .wb_rd(rd1), .wb_we(we1), .wb_err(e1),
        .halted(h1), .retired(r1));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one write-back slot per instance.
    int          nsrc [2] = '{4, 3};
    int          rmax [2] = '{65535, 15};
    bit          mv [2], mwe [2], merr [2], mh [2];
    int          mret [2];
    logic [15:0] md [2];
    logic [2:0]  mrd [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; mwe[i] = 0; merr[i] = 0; mh[i] = 0; mret[i] = 0;
            md[i] = '0; mrd[i] = '0;
        end
    endtask

    // What happens to each slot at the next rising edge, given current inputs.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit take, retire_now, fault_seen, bad;
            take       = in_valid && !stall && !flush && !mh[i];
            retire_now = mv[i] && !merr[i] && !stall && !flush;
            fault_seen = mv[i] && merr[i] && !flush;
            bad        = (int'(src_sel) >= nsrc[i]);
            if (flush) begin
                mv[i] = 0; merr[i] = 0;
            end else if (!stall) begin
                if (take) begin
                    mv[i]   = 1;
                    md[i]   = bad ? 16'h0 : src_data[int'(src_sel)*16 +: 16];
                    mrd[i]  = in_rd;
                    mwe[i]  = in_we;
                    merr[i] = in_ferr || in_merr || bad;
                end else begin
                    mv[i] = 0; merr[i] = 0;
                end
            end
            if (fault_seen) mh[i] = 1;
            if (retire_now && mret[i] < rmax[i]) mret[i]++;
        end
    endtask

    task automatic model_compare();
        chk("d0_valid", 32'(v0), 32'(mv[0]));
        if (mv[0]) begin
            chk("d0_data", 32'(d0), 32'(md[0]));
            chk("d0_rd", 32'(rd0), 32'(mrd[0]));
        end
        chk("d0_we", 32'(we0), 32'(mv[0] && mwe[0] && !merr[0]));
        chk("d0_err", 32'(e0), 32'(merr[0]));
        chk("d0_halted", 32'(h0), 32'(mh[0]));
        chk("d0_retired", 32'(r0), 32'(mret[0]));
        chk("d1_valid", 32'(v1), 32'(mv[1]));
        if (mv[1]) begin
            chk("d1_data", 32'(d1), 32'(md[1]));
            chk("d1_rd", 32'(rd1), 32'(mrd[1]));
        end
        chk("d1_we", 32'(we1), 32'(mv[1] && mwe[1] && !merr[1]));
        chk("d1_err", 32'(e1), 32'(merr[1]));
        chk("d1_halted", 32'(h1), 32'(mh[1]));
        chk("d1_retired", 32'(r1), 32'(mret[1]));
    endtask

    // Advance one clock with the inputs currently driven, then check.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        model_compare();
    endtask

    task automatic idle_inputs();
        in_valid = 0; stall = 0; flush = 0; src_sel = 0; in_rd = 0;
        in_we = 0; in_ferr = 0; in_merr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_d0", {v0, we0, e0, h0, 12'h0, r0}, 32'h0);
        chk("rst_d0_data", {13'h0, rd0, d0}, 32'h0);
        chk("rst_d1", {v1, we1, e1, h1, 12'h0, 12'h0, r1}, 32'h0);
        chk("rst_d1_data", {13'h0, rd1, d1}, 32'h0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        bit        rst;
        bit        v, st, fl;
        bit [1:0]  sel;
        bit [2:0]  rd;
        bit        we, fe, me;
        bit        e_valid;
        bit [15:0] e_data;
        bit [2:0]  e_rd;
        bit        e_we, e_err, e_h;
        bit [15:0] e_ret;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    initial begin
        // rst v st fl sel rd we fe me | valid data rd we err h ret
        tbl[0]  = '{0,1,0,0,2,5,1,0,0, 1,16'h3333,5,1,0,0,0};
        tbl[1]  = '{0,0,0,0,0,0,0,0,0, 0,16'h0000,0,0,0,0,1};
        tbl[2]  = '{0,1,0,0,0,1,1,0,0, 1,16'h1111,1,1,0,0,1};
        tbl[3]  = '{0,1,1,0,3,7,0,0,0, 1,16'h1111,1,1,0,0,1};
        tbl[4]  = '{0,1,1,0,3,7,0,0,0, 1,16'h1111,1,1,0,0,1};
        tbl[5]  = '{0,1,1,0,3,7,0,0,0, 1,16'h1111,1,1,0,0,1};
        tbl[6]  = '{0,1,0,0,3,7,0,0,0, 1,16'h4444,7,0,0,0,2};
        tbl[7]  = '{0,1,0,0,1,2,1,0,1, 1,16'h2222,2,0,1,0,3};
        tbl[8]  = '{0,0,0,0,0,0,0,0,0, 0,16'h0000,0,0,0,1,3};
        tbl[9]  = '{0,1,0,0,2,5,1,0,0, 0,16'h0000,0,0,0,1,3};
        tbl[10] = '{0,1,0,0,0,3,1,0,0, 0,16'h0000,0,0,0,1,3};
        tbl[11] = '{1,0,0,0,0,0,0,0,0, 0,16'h0000,0,0,0,0,0};
        tbl[12] = '{0,1,0,0,0,4,1,1,0, 1,16'h1111,4,0,1,0,0};
        tbl[13] = '{0,1,0,1,0,4,1,1,0, 0,16'h0000,0,0,0,0,0};
        tbl[14] = '{0,1,0,0,0,4,1,1,0, 1,16'h1111,4,0,1,0,0};
        tbl[15] = '{0,1,1,1,0,4,1,1,0, 0,16'h0000,0,0,0,0,0};
        tbl[16] = '{0,1,0,0,1,6,1,0,0, 1,16'h2222,6,1,0,0,0};
        tbl[17] = '{0,0,0,0,0,0,0,0,0, 0,16'h0000,0,0,0,0,1};
    end

    initial begin
        #1;
        do_reset();

        // Directed table on the default instance.
        src_data = {16'h0, 16'h0, 16'h0, 16'h0};
        src_data[63:0] = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int n = 0; n < NV; n++) begin
            if (tbl[n].rst) begin
                do_reset();
                $display("vec %0d: reset", n);
            end else begin
                in_valid = tbl[n].v;  stall = tbl[n].st; flush = tbl[n].fl;
                src_sel = tbl[n].sel; in_rd = tbl[n].rd;  in_we = tbl[n].we;
                in_ferr = tbl[n].fe;  in_merr = tbl[n].me;
                cycle();
                chk("tbl_valid", 32'(v0), 32'(tbl[n].e_valid));
                if (tbl[n].e_valid) begin
                    chk("tbl_data", 32'(d0), 32'(tbl[n].e_data));
                    chk("tbl_rd", 32'(rd0), 32'(tbl[n].e_rd));
                end
                chk("tbl_we", 32'(we0), 32'(tbl[n].e_we));
                chk("tbl_err", 32'(e0), 32'(tbl[n].e_err));
                chk("tbl_halted", 32'(h0), 32'(tbl[n].e_h));
                chk("tbl_retired", 32'(r0), 32'(tbl[n].e_ret));
                $display("vec %0d: v=%0b data=%h rd=%0d we=%0b err=%0b h=%0b ret=%0d",
                         n, v0, d0, rd0, we0, e0, h0, r0);
            end
        end

        // Back-to-back stream of 10, selects cycling through all four sources.
        do_reset();
        for (int n = 0; n < 10; n++) begin
            in_valid = 1; src_sel = 2'(n % 4); in_rd = 3'(n); in_we = 1;
            cycle();
            chk("stream_data", 32'(d0), 32'(16'h1111 * ((n % 4) + 1)));
            $display("stream %0d: data=%h rd=%0d", n, d0, rd0);
        end
        idle_inputs();
        cycle();
        chk("stream_retired", 32'(r0), 32'd10);
        $display("stream drained: retired=%0d", r0);

        // Saturation of the 4-bit counter (selects kept legal for NSRC=3).
        do_reset();
        for (int n = 0; n < 20; n++) begin
            in_valid = 1; src_sel = 2'(n % 3); in_rd = 3'(n); in_we = 1;
            cycle();
        end
        idle_inputs();
        cycle();
        chk("sat_retired_cw4", 32'(r1), 32'd15);
        chk("sat_retired_cw16", 32'(r0), 32'd20);
        $display("saturation: retired cw4=%0d cw16=%0d", r1, r0);

        // Out-of-range select on the NSRC=3 instance.
        do_reset();
        in_valid = 1; src_sel = 3; in_rd = 2; in_we = 1;
        cycle();
        chk("oor_data", 32'(d1), 32'h0);
        chk("oor_err", 32'(e1), 32'h1);
        chk("oor_we", 32'(we1), 32'h0);
        idle_inputs();
        cycle();
        chk("oor_halted", 32'(h1), 32'h1);
        chk("oor_d0_halted", 32'(h0), 32'h0);
        $display("out-of-range select: data=%h err=%0b halted=%0b", d1, e1, h1);

        // Fault entry held under stall: halt sets on the first stalled edge.
        do_reset();
        in_valid = 1; src_sel = 0; in_rd = 1; in_merr = 1;
        cycle();
        in_merr = 0; stall = 1;
        cycle();
        chk("stall_fault_halted", 32'(h0), 32'h1);
        chk("stall_fault_held", 32'(v0 & e0), 32'h1);
        $display("fault under stall: valid=%0b err=%0b halted=%0b", v0, e0, h0);
        do_reset();

        // Randomized traffic against the model, with periodic resets.
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 49) begin
                do_reset();
            end
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            src_sel  = 2'($urandom_range(0, 3));
            in_rd    = 3'($urandom_range(0, 7));
            in_we    = 1'($urandom_range(0, 1));
            in_ferr  = ($urandom_range(0, 31) == 0);
            in_merr  = ($urandom_range(0, 31) == 0);
            src_data = {$urandom, $urandom};
            cycle();
            $display("rand %0d: v=%0b/%0b data=%h/%h h=%0b/%0b ret=%0d/%0d",
                     n, v0, v1, d0, d1, h0, h1, r0, r1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
